// File: rtl/muldiv_seq.sv
// Sequential 32-bit unsigned multiplier / signed divider with IDLE-BUSY-DONE handshake.
// The first BUSY cycle prepares operand magnitudes; ITER iteration cycles follow.
module muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cancel,
    input  logic [4:0]  operation,
    input  logic [31:0] Op1,
    input  logic [31:0] Op2,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        Stall,
    output logic        div_by_zero
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [4:0] OP_MULTU = 5'h0F;
    localparam logic [4:0] OP_DIV   = 5'h10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          prep;
    logic          is_div;
    logic [31:0]   op_a, op_b;
    logic [32:0]   acc;
    logic [31:0]   lo_q;
    logic [31:0]   dvs;

    logic          supported;
    logic [32:0]   nxt_acc;
    logic [31:0]   nxt_lo;
    logic [32:0]   shifted;
    logic [32:0]   sum;
    logic [31:0]   res_hi, res_lo;
    logic          res_dz;

    assign supported = (operation == OP_MULTU) || (operation == OP_DIV);
    assign Stall     = ~rst & ((state == BUSY) | ((state == IDLE) & start & supported));
    assign busy      = (state != IDLE);

    // One shift-add (multiply) or one restoring step (divide) per cycle.
    always_comb begin
        nxt_acc = acc;
        nxt_lo  = lo_q;
        shifted = {acc[31:0], lo_q[31]};
        sum     = {1'b0, acc[31:0]} + (lo_q[0] ? {1'b0, dvs} : 33'd0);
        if (is_div) begin
            if (shifted >= {1'b0, dvs}) begin
                nxt_acc = shifted - {1'b0, dvs};
                nxt_lo  = {lo_q[30:0], 1'b1};
            end else begin
                nxt_acc = shifted;
                nxt_lo  = {lo_q[30:0], 1'b0};
            end
        end else begin
            nxt_acc = {1'b0, sum[32:1]};
            nxt_lo  = {sum[0], lo_q[31:1]};
        end
    end

    // Final result from the last iteration; divide results are sign-corrected here.
    always_comb begin
        res_hi = nxt_acc[31:0];
        res_lo = nxt_lo;
        res_dz = 1'b0;
        if (is_div) begin
            if (op_b == 32'd0) begin
                res_hi = op_a;
                res_lo = 32'hFFFF_FFFF;
                res_dz = 1'b1;
            end else begin
                res_lo = (op_a[31] ^ op_b[31]) ? -nxt_lo : nxt_lo;
                res_hi = op_a[31] ? -nxt_acc[31:0] : nxt_acc[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            prep        <= 1'b0;
            is_div      <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            acc         <= '0;
            lo_q        <= '0;
            dvs         <= '0;
            HI          <= '0;
            LO          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (start && supported) begin
                        state  <= BUSY;
                        cnt    <= '0;
                        prep   <= 1'b1;
                        is_div <= (operation == OP_DIV);
                        op_a   <= Op1;
                        op_b   <= Op2;
                    end
                end
                BUSY: begin
                    if (cancel) begin
                        state <= IDLE;
                        prep  <= 1'b0;
                    end else if (prep) begin
                        prep <= 1'b0;
                        acc  <= '0;
                        lo_q <= (is_div && op_a[31]) ? -op_a : op_a;
                        dvs  <= (is_div && op_b[31]) ? -op_b : op_b;
                    end else begin
                        acc  <= nxt_acc;
                        lo_q <= nxt_lo;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(ITER - 1)) begin
                            state       <= DONE;
                            HI          <= res_hi;
                            LO          <= res_lo;
                            done        <= 1'b1;
                            div_by_zero <= res_dz;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, results, cancel, reset and ignored starts.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [4:0]  operation = 5'h0;
    logic [31:0] Op1 = '0, Op2 = '0;
    logic [31:0] HI, LO;
    logic        busy, done, Stall, div_by_zero;

    int n_chk = 0;
    int n_err = 0;

    muldiv_seq #(.ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel),
        .operation(operation), .Op1(Op1), .Op2(Op2),
        .HI(HI), .LO(LO), .busy(busy), .done(done),
        .Stall(Stall), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and check the whole timeline up to one cycle after done.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edz);
        int stall_bad, done_early, dz_cnt;
        stall_bad = 0; done_early = 0; dz_cnt = 0;
        operation = op; Op1 = a; Op2 = b; start = 1'b1;
        #1;
        check({tag, " stall_req"}, 64'(Stall), 64'd1);
        tick();
        start = 1'b0; Op1 = '0; Op2 = '0;
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) tick();
            if (Stall !== (k < 33)) stall_bad++;
            if (k < 33 && done !== 1'b0) done_early++;
            if (div_by_zero === 1'b1) dz_cnt++;
        end
        check({tag, " stall_window"}, 64'(stall_bad), 64'd0);
        check({tag, " done_early"}, 64'(done_early), 64'd0);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy_done"}, 64'(busy), 64'd1);
        check({tag, " HI"}, 64'(HI), 64'(ehi));
        check({tag, " LO"}, 64'(LO), 64'(elo));
        check({tag, " dz"}, 64'(div_by_zero), 64'(edz));
        tick();
        if (div_by_zero === 1'b1) dz_cnt++;
        check({tag, " dz_pulses"}, 64'(dz_cnt), 64'(edz));
        check({tag, " done_after"}, 64'(done), 64'd0);
        check({tag, " busy_after"}, 64'(busy), 64'd0);
        check({tag, " hold"}, {HI, LO}, {ehi, elo});
    endtask

    initial begin
        int dn;
        // Reset, with a supported start held to show Stall is masked.
        start = 1'b1; operation = 5'h0F; Op1 = 32'd9; Op2 = 32'd9;
        tick(); tick();
        check("rst stall", 64'(Stall), 64'd0);
        check("rst HI", 64'(HI), 64'd0);
        check("rst LO", 64'(LO), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst dz", 64'(div_by_zero), 64'd0);
        start = 1'b0; rst = 1'b0;
        tick();

        run_op("mul", 5'h0F, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0);
        run_op("mul_big", 5'h0F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("div", 5'h10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_pn", 5'h10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
        run_op("div_ovf", 5'h10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_op("div0", 5'h10, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);

        // Unsupported opcode in IDLE is ignored.
        operation = 5'h03; Op1 = 32'd1; Op2 = 32'd1; start = 1'b1;
        #1;
        check("bad_op stall", 64'(Stall), 64'd0);
        tick();
        start = 1'b0;
        check("bad_op busy", 64'(busy), 64'd0);
        check("bad_op hold", {HI, LO}, {32'h1234_5678, 32'hFFFF_FFFF});

        // Start during BUSY is ignored; exactly one done with the original result.
        operation = 5'h0F; Op1 = 32'd3; Op2 = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        dn = 0;
        for (int k = 0; k < 45; k++) begin
            if (k == 5) begin
                operation = 5'h10; Op1 = 32'd77; Op2 = 32'd7; start = 1'b1;
            end
            if (k == 6) start = 1'b0;
            tick();
            if (done === 1'b1) dn++;
        end
        check("busy_start done_cnt", 64'(dn), 64'd1);
        check("busy_start result", {HI, LO}, {32'd0, 32'd15});

        // Cancel at BUSY cycle 10.
        operation = 5'h0F; Op1 = 32'd1000; Op2 = 32'd1000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel stall", 64'(Stall), 64'd0);
        check("cancel hold", {HI, LO}, {32'd0, 32'd15});
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done === 1'b1) dn++;
        end
        check("cancel no_done", 64'(dn), 64'd0);

        // Reset at BUSY cycle 20, then a full-latency op.
        operation = 5'h10; Op1 = 32'd50; Op2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        rst = 1'b1;
        tick();
        check("midrst HI", 64'(HI), 64'd0);
        check("midrst LO", 64'(LO), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done === 1'b1) dn++;
        end
        check("midrst no_done", 64'(dn), 64'd0);
        run_op("post_rst", 5'h10, 32'd50, 32'd3, 32'd2, 32'd16, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter ITER, default 32, giving the number of iteration cycles per operation.
REQ-002 SHALL have ports:
  - clk  in  1  rising-edge clock
  - rst  in  1  synchronous, active-high reset
  - start  in  1  request to begin an operation
  - cancel  in  1  pipeline flush; aborts the operation in flight
  - operation  in  5  opcode; 5'hF = unsigned multiply, 5'h10 = signed divide, all other values unsupported
  - Op1  in  32  multiplicand or dividend (rs)
  - Op2  in  32  multiplier or divisor (rt)
  - HI  out  32  product[63:32] or remainder
  - LO  out  32  product[31:0] or quotient
  - busy  out  1  operation in flight
  - done  out  1  one-cycle completion pulse
  - Stall  out  1  freeze request to the pipeline
  - div_by_zero  out  1  one-cycle flag, coincident with done
REQ-003 SHALL use one clock domain (clk) and synchronous active-high reset (rst), as already decided.

Function
REQ-004 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-005 IDLE->BUSY SHALL occur when start=1 and operation is 5'hF or 5'h10; Op1, Op2 and operation SHALL be latched on that edge and the iteration counter cleared to 0.
REQ-006 start with an unsupported operation SHALL be ignored: state remains IDLE, no outputs change.
REQ-007 BUSY SHALL perform exactly one iteration per cycle and increment the counter; BUSY->DONE SHALL occur when counter=ITER-1.
REQ-008 DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-009 done and div_by_zero SHALL be registered and high only in DONE; HI/LO SHALL update on the edge entering DONE.
REQ-010 Latency: if start is accepted at edge N, done SHALL be high during the cycle following edge N+ITER+1, i.e. 33 cycles after acceptance for ITER=32.
REQ-011 Multiply SHALL be unsigned shift-add over 32 bits, giving a 64-bit product {HI,LO}.
REQ-012 Divide SHALL be restoring division on magnitudes, then sign-corrected:
  - quotient truncates toward zero; quotient sign = Op1[31]^Op2[31]
  - remainder sign follows Op1
REQ-013 Divide of -2^31 by -1 SHALL give LO=32'h80000000, HI=0, with no flag raised.
REQ-014 Divide by zero SHALL still take full latency and give LO=32'hFFFFFFFF, HI=Op1, div_by_zero=1.
REQ-015 busy SHALL be 1 in BUSY and DONE, 0 in IDLE.
REQ-016 Stall SHALL be combinational and equal (state==BUSY) | (state==IDLE & start & supported operation); Stall SHALL be 0 in DONE so the dependent instruction advances.
REQ-017 start while in BUSY or DONE SHALL be ignored; latched operands SHALL not change.
REQ-018 cancel=1 in BUSY or DONE SHALL force IDLE on the next edge, with HI/LO unchanged and no done pulse.
REQ-019 cancel SHALL take priority over start in the same cycle.
REQ-020 cancel in IDLE SHALL have no effect.
REQ-021 HI/LO SHALL hold their last completed result indefinitely while IDLE.

Reset
REQ-022 rst=1 SHALL, on the next rising clk edge and from any state, force IDLE, counter=0 and HI=LO=0; busy, done and div_by_zero SHALL be 0.
REQ-023 Stall SHALL read 0 while rst=1.
REQ-024 rst SHALL take priority over cancel and start.
REQ-025 rst mid-operation SHALL discard the operation with no done pulse.

Verification
REQ-026 Multiply: Op1=32'hFFFFFFFF, Op2=32'h2, operation=5'hF, start=1 -> after 33 cycles done=1, HI=32'h1, LO=32'hFFFFFFFE; Stall high for cycles 0..32.
REQ-027 Divide: Op1=-7, Op2=2, operation=5'h10 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1), div_by_zero=0.
REQ-028 Divide by zero: Op1=32'h12345678, Op2=0 -> done with LO=32'hFFFFFFFF, HI=32'h12345678, div_by_zero=1 for exactly one cycle.
REQ-029 Cancel: cancel pulsed at BUSY cycle 10 -> IDLE next cycle, no done pulse, HI/LO equal to the previous result.
REQ-030 Reset mid-operation: rst asserted at BUSY cycle 20 -> HI=LO=0, busy=0; a new start afterwards completes with the full 33-cycle latency.
REQ-031 Ignored start: start with operation=5'h3 in IDLE, and start pulsed during BUSY -> neither is accepted; exactly one done pulse results from the original request.
